cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Clocking and reset SHALL be fixed as: one clock; reset is asynchronous and active-low.
REQ-002 Parameter: BLOCK_WORDS, default 8, words per cache block (16 B block, 16-bit words).
REQ-003 Parameter: MEM_LATENCY, default 4, memory read latency in cycles; informational only, the FSM is latency-agnostic.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 miss_detected  input  1  cache lookup missed this cycle.
REQ-007 miss_address  input  16  CPU byte address of the missing access.
REQ-008 memory_data_valid  input  1  memory_data carries a returned word this cycle.
REQ-009 memory_data  input  16  word returned by memory.
REQ-010 fsm_busy  output  1  fill in progress; cache stalls the CPU.
REQ-011 mem_read_en  output  1  read request to memory this cycle.
REQ-012 memory_address  output  16  byte address of the current memory request.
REQ-013 write_data_array  output  1  write fill_data into the data array this cycle.
REQ-014 word_enable  output  8  one-hot word select within the block for the data-array write.
REQ-015 fill_data  output  16  word to write; equals memory_data.
REQ-016 write_tag_array  output  1  write the tag and set the valid bit for the filled set this cycle.

Function
REQ-017 The FSM SHALL have two states: IDLE and FILL.
REQ-018 In IDLE with miss_detected=1, the block SHALL latch base = {miss_address[15:4],4'b0000}, clear both counters, and enter FILL on the next edge.
REQ-019 fsm_busy SHALL be 1 combinationally in IDLE when miss_detected=1, and 1 throughout FILL.
REQ-020 In FILL, while issue_cnt < 8, the block SHALL assert mem_read_en with memory_address = base + 2*issue_cnt and increment issue_cnt, issuing one request per cycle with no gaps.
REQ-021 Once issue_cnt = 8, the block SHALL hold mem_read_en = 0 and memory_address = 0.
REQ-022 In FILL, each cycle with memory_data_valid=1, the block SHALL assert write_data_array, drive word_enable = 1 << recv_cnt and fill_data = memory_data, then increment recv_cnt.
REQ-023 On the cycle the 8th word is received (recv_cnt = 7 with memory_data_valid=1), the block SHALL also assert write_tag_array, and SHALL return to IDLE on the next edge.
REQ-024 With 4-cycle memory latency, a fill SHALL take 12 cycles from the first request to write_tag_array; fsm_busy SHALL fall the cycle after write_tag_array.
REQ-025 The block SHALL ignore miss_detected while in FILL; the miss is not queued.
REQ-026 The block SHALL ignore memory_data_valid while in IDLE: no write, no counter change.
REQ-027 Issue and receive SHALL overlap freely; a valid return on the same cycle as a request SHALL be handled independently.
REQ-028 Address arithmetic SHALL wrap modulo 2^16; base bits [3:0] SHALL always be 0.
REQ-029 Outside the conditions above, all strobes and word_enable SHALL be 0.

Reset
REQ-030 When rst=0, asynchronously: state = IDLE; issue_cnt, recv_cnt and base = 0; all outputs = 0.
REQ-031 A reset during FILL SHALL abandon the fill without asserting write_tag_array, leaving the tag array untouched.

Structure
REQ-032 A shared package cache_pkg SHALL hold the state enum (IDLE, FILL), BLOCK_WORDS, OFFSET_BITS = 3, and the block-alignment mask.
REQ-033 A sub-module word_counter SHALL implement the 4-bit saturating-at-8 counter, instantiated twice: once as issue_cnt and once as recv_cnt.

Verification
REQ-034 Single miss: miss_address = 0x1236, latency 4 -> requests 0x1230, 0x1232 ... 0x123E on consecutive cycles; word_enable 0x01 ... 0x80; write_tag_array on the 12th cycle of FILL; then IDLE.
REQ-035 Wrap: miss_address = 0xFFFA -> base 0xFFF0, last request 0xFFFE, no overflow into other bits.
REQ-036 Gapped returns: memory_data_valid toggles on alternate cycles -> exactly 8 writes in order, write_tag_array only with the 8th.
REQ-037 Miss during FILL: miss_detected held high throughout the fill -> no restart; after returning to IDLE, a new fill starts on the following cycle.
REQ-038 Reset mid-fill after 3 words received -> all outputs 0 immediately; write_tag_array never asserted; next miss restarts from word 0.
REQ-039 Stray return: memory_data_valid = 1 in IDLE -> no write_data_array and no state change.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache block fill controller: state encoding,
// block geometry and the address alignment helper.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = 3;
    localparam int CNT_W       = 4;

    // A block is 16 bytes, so the low four byte-address bits are the offset.
    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & BLOCK_MASK;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Saturating word counter used to track requests issued and words received
// during a block fill. Counts up to MAX and then holds.
module word_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i && (cnt_q < MAX_V)) begin
            cnt_d = cnt_q + ONE_V;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block-fill controller. On a miss it streams one read request
// per cycle for every word of the block, writes returned words into the data
// array as they arrive (in any timing), and writes the tag with the last word.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [7:0]  word_enable,
    output logic [15:0] fill_data,
    output logic        write_tag_array
);

    import cache_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    // The datapath widths (8-bit word_enable, 3-bit offset) fix the block size;
    // the memory latency only has to be a real, positive number of cycles.
    if ((BLOCK_WORDS != 8) || (MEM_LATENCY < 1)) begin : g_param_check
        $error("cache_fill_fsm: unsupported BLOCK_WORDS or MEM_LATENCY");
    end

    fill_state_e      state_q;
    fill_state_e      state_d;
    logic [15:0]      base_q;
    logic [15:0]      base_d;
    logic [CNT_W-1:0] issue_cnt_s;
    logic [CNT_W-1:0] recv_cnt_s;
    logic             cnt_clr_s;
    logic             issue_inc_s;
    logic             recv_inc_s;
    logic             busy_s;

    word_counter #(.W(CNT_W), .MAX(BLOCK_WORDS)) u_issue_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (cnt_clr_s),
        .inc_i  (issue_inc_s),
        .cnt_o  (issue_cnt_s)
    );

    word_counter #(.W(CNT_W), .MAX(BLOCK_WORDS)) u_recv_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (cnt_clr_s),
        .inc_i  (recv_inc_s),
        .cnt_o  (recv_cnt_s)
    );

    // Next-state, counter control and per-cycle strobes; issue and receive
    // paths are evaluated independently so they can overlap in any cycle.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        cnt_clr_s        = 1'b0;
        issue_inc_s      = 1'b0;
        recv_inc_s       = 1'b0;
        busy_s           = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        word_enable      = 8'h00;
        fill_data        = 16'h0000;
        write_tag_array  = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    busy_s    = 1'b1;
                    base_d    = block_base(miss_address);
                    cnt_clr_s = 1'b1;
                    state_d   = FILL;
                end else begin
                    state_d   = IDLE;
                end
            end
            FILL: begin
                busy_s = 1'b1;
                if (issue_cnt_s < CNT_MAX) begin
                    mem_read_en    = 1'b1;
                    memory_address = base_q + {11'b000_0000_0000, issue_cnt_s, 1'b0};
                    issue_inc_s    = 1'b1;
                end else begin
                    mem_read_en    = 1'b0;
                    memory_address = 16'h0000;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_enable      = 8'b0000_0001 << recv_cnt_s[OFFSET_BITS-1:0];
                    fill_data        = memory_data;
                    recv_inc_s       = 1'b1;
                    if (recv_cnt_s == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end else begin
                        state_d         = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and block base registers; reset abandons any fill in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // Busy may follow the miss input combinationally, so hold it low in reset.
    assign fsm_busy = rst & busy_s;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a literal vector table for the
// reference miss, directed corner sequences, and a randomized run checked
// against a transaction-level model of the fill.
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0000;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h0000;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [7:0]  word_enable;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm #(.BLOCK_WORDS(8), .MEM_LATENCY(LAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_enable       (word_enable),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        miss;
        logic [15:0] maddr;
        logic        valid;
        logic [15:0] mdata;
        logic        busy;
        logic        rd;
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  we;
        logic [15:0] fd;
        logic        tag;
    } vec_t;

    vec_t tbl[16];

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: in a fill, how many requests/words so far.
    logic        m_fill = 1'b0;
    logic [15:0] m_base = 16'h0000;
    int          m_iss  = 0;
    int          m_rcv  = 0;
    int          cyc    = 0;
    logic [15:0] pend_addr[$];
    int          pend_t[$];
    int          dut_wr_cnt  = 0;
    int          dut_tag_cnt = 0;
    logic [15:0] dut_last_req = 16'h0000;

    function automatic vec_t mk(input logic miss, input logic [15:0] maddr,
                                input logic valid, input logic [15:0] mdata,
                                input logic busy, input logic rd, input logic [15:0] addr,
                                input logic wr, input logic [7:0] we, input logic [15:0] fd,
                                input logic tag);
        vec_t v;
        v.miss = miss; v.maddr = maddr; v.valid = valid; v.mdata = mdata;
        v.busy = busy; v.rd = rd; v.addr = addr; v.wr = wr; v.we = we; v.fd = fd; v.tag = tag;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tagname, input logic busy, input logic rd,
                               input logic [15:0] addr, input logic wr, input logic [7:0] we,
                               input logic [15:0] fd, input logic tag);
        chk({tagname, ".fsm_busy"},         {15'h0, fsm_busy},         {15'h0, busy});
        chk({tagname, ".mem_read_en"},      {15'h0, mem_read_en},      {15'h0, rd});
        chk({tagname, ".memory_address"},   memory_address,            addr);
        chk({tagname, ".write_data_array"}, {15'h0, write_data_array}, {15'h0, wr});
        chk({tagname, ".word_enable"},      {8'h00, word_enable},      {8'h00, we});
        chk({tagname, ".write_tag_array"},  {15'h0, write_tag_array},  {15'h0, tag});
        if (wr) chk({tagname, ".fill_data"}, fill_data, fd);
    endtask

    // One clock cycle against the model; called just after a falling edge.
    task automatic cycle(input logic miss, input logic [15:0] maddr,
                         input logic valid, input logic [15:0] mdata);
        logic        e_busy, e_rd, e_wr, e_tag;
        logic [15:0] e_addr, e_fd;
        logic [7:0]  e_we;
        miss_detected     = miss;
        miss_address      = maddr;
        memory_data_valid = valid;
        memory_data       = mdata;
        #1;
        e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_tag = 1'b0;
        e_addr = 16'h0000; e_fd = 16'h0000; e_we = 8'h00;
        if (!m_fill) begin
            e_busy = miss;
        end else begin
            e_busy = 1'b1;
            if (m_iss < 8) begin
                e_rd   = 1'b1;
                e_addr = m_base + 16'(2 * m_iss);
            end
            if (valid) begin
                e_wr  = 1'b1;
                e_we  = 8'(1 << m_rcv);
                e_fd  = mdata;
                e_tag = (m_rcv == 7);
            end
        end
        chk_outputs("seq", e_busy, e_rd, e_addr, e_wr, e_we, e_fd, e_tag);
        if (write_data_array) dut_wr_cnt++;
        if (write_tag_array)  dut_tag_cnt++;
        if (mem_read_en)      dut_last_req = memory_address;
        if (e_rd) begin
            pend_addr.push_back(e_addr);
            pend_t.push_back(cyc);
        end
        if (!m_fill) begin
            if (miss) begin
                m_fill = 1'b1;
                m_base = maddr & 16'hFFF0;
                m_iss  = 0;
                m_rcv  = 0;
            end
        end else begin
            if (m_iss < 8) m_iss++;
            if (valid) begin
                if (m_rcv == 7) m_fill = 1'b0;
                m_rcv++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Memory returns the oldest request once LAT cycles old.
    // mode 0: as soon as ready; 1: odd cycles only; 2: random.
    task automatic mem_cycle(input logic miss, input logic [15:0] maddr, input int mode);
        logic        v;
        logic [15:0] d;
        logic        ok;
        v = 1'b0;
        d = 16'h0000;
        if (pend_addr.size() > 0 && (cyc - pend_t[0]) >= LAT) begin
            if (mode == 0)      ok = 1'b1;
            else if (mode == 1) ok = ((cyc % 2) == 1);
            else                ok = 1'($urandom_range(1, 0));
            if (ok) begin
                v = 1'b1;
                d = pend_addr[0] ^ 16'h5A5A;
                void'(pend_addr.pop_front());
                void'(pend_t.pop_front());
            end
        end
        cycle(miss, maddr, v, d);
    endtask

    task automatic run_fill(input logic [15:0] addr, input int mode, input logic hold_miss);
        int n;
        mem_cycle(1'b1, addr, mode);
        n = 0;
        while (m_fill && n < 100) begin
            mem_cycle(hold_miss, 16'($urandom), mode);
            n++;
        end
        chk("fill_completes", {15'h0, m_fill}, 16'h0000);
    endtask

    task automatic clear_counts();
        dut_wr_cnt  = 0;
        dut_tag_cnt = 0;
    endtask

    initial begin
        // Reference miss at 0x1236 with 4-cycle memory, then stray returns.
        tbl[0]  = mk(1'b1, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
        tbl[1]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 8'h00, 16'h0000, 1'b0);
        tbl[2]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 8'h00, 16'h0000, 1'b0);
        tbl[3]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 8'h00, 16'h0000, 1'b0);
        tbl[4]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b0, 8'h00, 16'h0000, 1'b0);
        tbl[5]  = mk(1'b0, 16'h0000, 1'b1, 16'hD000, 1'b1, 1'b1, 16'h1238, 1'b1, 8'h01, 16'hD000, 1'b0);
        tbl[6]  = mk(1'b0, 16'h0000, 1'b1, 16'hD001, 1'b1, 1'b1, 16'h123A, 1'b1, 8'h02, 16'hD001, 1'b0);
        tbl[7]  = mk(1'b0, 16'h0000, 1'b1, 16'hD002, 1'b1, 1'b1, 16'h123C, 1'b1, 8'h04, 16'hD002, 1'b0);
        tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 16'hD003, 1'b1, 1'b1, 16'h123E, 1'b1, 8'h08, 16'hD003, 1'b0);
        tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 16'hD004, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h10, 16'hD004, 1'b0);
        tbl[10] = mk(1'b0, 16'h0000, 1'b1, 16'hD005, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h20, 16'hD005, 1'b0);
        tbl[11] = mk(1'b0, 16'h0000, 1'b1, 16'hD006, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h40, 16'hD006, 1'b0);
        tbl[12] = mk(1'b0, 16'h0000, 1'b1, 16'hD007, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h80, 16'hD007, 1'b1);
        tbl[13] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
        tbl[14] = mk(1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
        tbl[15] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);

        // Reset state, with active-looking inputs held during reset.
        miss_detected     = 1'b1;
        miss_address      = 16'h1234;
        memory_data_valid = 1'b1;
        memory_data       = 16'hAAAA;
        #2;
        chk_outputs("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
        @(negedge clk);
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            miss_detected     = tbl[i].miss;
            miss_address      = tbl[i].maddr;
            memory_data_valid = tbl[i].valid;
            memory_data       = tbl[i].mdata;
            #1;
            chk_outputs($sformatf("vec%0d", i), tbl[i].busy, tbl[i].rd, tbl[i].addr,
                        tbl[i].wr, tbl[i].we, tbl[i].fd, tbl[i].tag);
            cyc++;
            @(negedge clk);
        end

        // Wrap at the top of the address space.
        clear_counts();
        run_fill(16'hFFFA, 0, 1'b0);
        chk("wrap.last_request", dut_last_req, 16'hFFFE);
        chk("wrap.writes", 16'(dut_wr_cnt), 16'd8);
        chk("wrap.tags", 16'(dut_tag_cnt), 16'd1);

        // Returns on alternate cycles only.
        clear_counts();
        run_fill(16'h4A1C, 1, 1'b0);
        chk("gapped.writes", 16'(dut_wr_cnt), 16'd8);
        chk("gapped.tags", 16'(dut_tag_cnt), 16'd1);

        // Miss held high during a fill: no restart; back-to-back fill after.
        clear_counts();
        run_fill(16'h2002, 0, 1'b1);
        chk("missheld.writes", 16'(dut_wr_cnt), 16'd8);
        chk("missheld.tags", 16'(dut_tag_cnt), 16'd1);
        mem_cycle(1'b1, 16'h3456, 0);
        chk("b2b.first_req_en", {15'h0, mem_read_en}, 16'h0001);
        chk("b2b.first_req_addr", memory_address, 16'h3450);
        begin
            int n = 0;
            while (m_fill && n < 100) begin
                mem_cycle(1'b0, 16'h0000, 0);
                n++;
            end
        end
        chk("b2b.tags", 16'(dut_tag_cnt), 16'd2);

        // Reset after three words of a fill have been written.
        clear_counts();
        mem_cycle(1'b1, 16'h7777, 0);
        begin
            int n = 0;
            while (m_rcv < 3 && n < 100) begin
                mem_cycle(1'b0, 16'h0000, 0);
                n++;
            end
        end
        chk("midreset.words_before", 16'(dut_wr_cnt), 16'd3);
        miss_detected     = 1'b1;
        memory_data_valid = 1'b1;
        memory_data       = 16'h1111;
        rst = 1'b0;
        #1;
        chk_outputs("midreset", 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
        chk("midreset.tags", 16'(dut_tag_cnt), 16'd0);
        m_fill = 1'b0;
        m_iss  = 0;
        m_rcv  = 0;
        pend_addr.delete();
        pend_t.delete();
        @(negedge clk);
        rst = 1'b1;
        clear_counts();
        run_fill(16'h7777, 0, 1'b0);
        chk("restart.writes", 16'(dut_wr_cnt), 16'd8);
        chk("restart.tags", 16'(dut_tag_cnt), 16'd1);

        // Randomized traffic: misses, random return gaps, stray returns in IDLE.
        for (int i = 0; i < 600; i++) begin
            if (!m_fill) begin
                cycle(($urandom_range(3, 0) == 0), 16'($urandom),
                      ($urandom_range(7, 0) == 0), 16'($urandom));
            end else begin
                mem_cycle(1'($urandom_range(1, 0)), 16'($urandom), 2);
            end
        end
        begin
            int n = 0;
            while (m_fill && n < 200) begin
                mem_cycle(1'b0, 16'h0000, 2);
                n++;
            end
        end
        chk("random.drained", {15'h0, m_fill}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
